hh_seq_ctrl: RTL
================

HH_SEQ_CTRL -- requirements
Module: hh_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stimulus/result word width.
REQ-002 SHALL have parameter STEP_W, default 16, step-count width (1..32).
REQ-003 SHALL have parameter CNT_W, default 64, cycle-counter width (33..64).
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports i_data/i_valid/o_ready  in/in/out  DATA_W/1/1  stimulus sink from FIFO.
REQ-007 SHALL have ports eng_o_data/eng_o_valid/eng_i_ready  out/out/in  DATA_W/1/1  stimulus to neuron engine.
REQ-008 SHALL have ports eng_i_data/eng_i_valid/eng_o_ready  in/in/out  DATA_W/1/1  engine result.
REQ-009 SHALL have ports o_data/o_valid/i_ready  out/out/in  DATA_W/1/1  result source to FIFO.
REQ-010 SHALL have ports i_address/i_writedata/i_write/i_read/o_readdata/o_waitrequest  in/in/in/in/out/out  3/32/1/1/32/1  Avalon-MM CSR slave.
REQ-011 SHALL have port o_irq  output  1  done interrupt (see Configuration).

Function
REQ-012 CSR map SHALL be: 0 CTRL (W: bit0 start, bit1 abort, bit2 irq_en), 1 STEPS (R/W, [STEP_W-1:0]), 2 STATUS (R: bit0 busy, bit1 done, bit2 aborted, bit3 start_err; W1C bits1-3), 3 CYC_LO, 4 CYC_HI (CNT_W-32 bits, zero-extended), 5 OUTSTANDING (R).
REQ-013 o_waitrequest SHALL be 0 always; o_readdata combinational, 0 for unmapped addresses.
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE/DONE + start write SHALL latch STEPS into remaining, clear cycle counter, done, aborted, then enter RUN next cycle (STEPS=0 enters DONE directly).
REQ-016 Start while RUN/DRAIN SHALL be ignored and set start_err.
REQ-017 In RUN stimulus path SHALL be pass-through: eng_o_data=i_data, eng_o_valid=i_valid, o_ready=eng_i_ready; o_ready and eng_o_valid 0 in other states.
REQ-018 Each stimulus transfer SHALL decrement issue count; at zero SHALL move to DRAIN same edge.
REQ-019 Result path SHALL be pass-through in all states: o_data=eng_i_data, o_valid=eng_i_valid, eng_o_ready=i_ready.
REQ-020 Outstanding count (STEP_W+1 bits) SHALL +1 per stimulus transfer, -1 per result transfer, unchanged on simultaneous both.
REQ-021 DRAIN SHALL enter DONE when outstanding reaches 0; DONE sets done=1.
REQ-022 Abort write in RUN SHALL enter DRAIN next cycle and set aborted; abort in other states ignored; abort and start same write: abort wins.
REQ-023 Cycle counter SHALL increment each cycle in RUN or DRAIN, saturate at all-ones, hold otherwise.
REQ-024 Read of CYC_LO SHALL snapshot upper bits into shadow register returned by next CYC_HI read (atomic 64-bit read).

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, all counters/flags/shadow/STEPS/irq_en to 0, o_irq=0; stream outputs follow REQ-017/019 combinationally.
REQ-026 Reset mid-run SHALL discard outstanding tracking; results arriving afterwards pass through without effect on state.

Configuration
REQ-027 Macro HH_SEQ_CTRL_IRQ_EN defined: o_irq = done & irq_en, registered, cleared by W1C of done.
REQ-028 Macro undefined: o_irq tied 0, irq_en bit reads 0, no IRQ logic.

Verification
REQ-029 STEPS=4, start, engine 3-cycle latency -> 4 stimulus and 4 result transfers, DONE, STATUS=0x2, cycles reported equal cycles in RUN+DRAIN.
REQ-030 STEPS=0, start -> DONE next cycle, zero transfers, CYC_LO=0.
REQ-031 STEPS=10, abort after 3 issued -> no further o_ready, DRAIN until 3 results, STATUS=0x6.
REQ-032 Start during RUN -> STATUS bit3 set, run unaffected; W1C 0x8 clears it.
REQ-033 Counter preset near 2^32-1, read LO then HI across carry -> consistent 64-bit value; with HH_SEQ_CTRL_IRQ_EN, irq_en=1 -> o_irq rises one cycle after done.
REQ-034 reset_n low in DRAIN with 2 outstanding -> IDLE, OUTSTANDING=0, o_irq=0 immediately.

Source files
------------

// File: rtl/hh_seq_ctrl.sv
// hh_seq_ctrl -- run sequencer for a neuron engine.
// Stimulus words pass from an input FIFO to the engine while a run is
// active. Results pass from the engine to an output FIFO at all times.
// An Avalon-MM CSR block starts and aborts runs, counts busy cycles and
// tracks how many stimulus words are still waiting for a result.
// CYC_LO and CYC_HI can also be written, so the cycle counter can be
// preset (for example to test the carry into the upper word).
// Optional feature: define HH_SEQ_CTRL_IRQ_EN to build the done interrupt.
// Without it, o_irq is tied low and the CTRL irq_en bit reads as 0.
module hh_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int STEP_W = 16,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] eng_o_data,
  output logic              eng_o_valid,
  input  logic              eng_i_ready,
  input  logic [DATA_W-1:0] eng_i_data,
  input  logic              eng_i_valid,
  output logic              eng_o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  input  logic [2:0]        i_address,
  input  logic [31:0]       i_writedata,
  input  logic              i_write,
  input  logic              i_read,
  output logic [31:0]       o_readdata,
  output logic              o_waitrequest,
  output logic              o_irq
);

  localparam int HI_W  = CNT_W - 32;
  localparam int OUT_W = STEP_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [HI_W-1:0]   shadow_q, shadow_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              start_err_q, start_err_d;
  logic              irq_en_s;

  logic ctrl_wr_s, steps_wr_s, status_wr_s, cyc_lo_wr_s, cyc_hi_wr_s;
  logic start_req_s, abort_req_s, busy_s;
  logic stim_xfer_s, res_xfer_s;

  // CSR write decode and stream handshake qualification.
  assign ctrl_wr_s   = i_write && (i_address == 3'd0);
  assign steps_wr_s  = i_write && (i_address == 3'd1);
  assign status_wr_s = i_write && (i_address == 3'd2);
  assign cyc_lo_wr_s = i_write && (i_address == 3'd3);
  assign cyc_hi_wr_s = i_write && (i_address == 3'd4);
  assign start_req_s = ctrl_wr_s && i_writedata[0];
  assign abort_req_s = ctrl_wr_s && i_writedata[1];
  assign busy_s      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign stim_xfer_s = (state_q == ST_RUN) && i_valid && eng_i_ready;
  // After a reset the tracker is empty. Results that arrive later are
  // stale, so they must not drive the count below zero.
  assign res_xfer_s  = eng_i_valid && i_ready && (outstanding_q != '0);

  // Stimulus is gated by the run state. Results always pass straight through.
  assign eng_o_data    = i_data;
  assign eng_o_valid   = (state_q == ST_RUN) && i_valid;
  assign o_ready       = (state_q == ST_RUN) && eng_i_ready;
  assign o_data        = eng_i_data;
  assign o_valid       = eng_i_valid;
  assign eng_o_ready   = i_ready;
  assign o_waitrequest = 1'b0;

`ifdef HH_SEQ_CTRL_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  // Interrupt enable register and the registered done interrupt.
  always_comb begin
    irq_en_d = irq_en_q;
    if (ctrl_wr_s) begin
      irq_en_d = i_writedata[2];
    end else begin
      irq_en_d = irq_en_q;
    end
    // The interrupt drops on the same edge that a W1C clears done.
    irq_d = done_q && irq_en_q && !(status_wr_s && i_writedata[1]);
  end

  // Interrupt state flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en_s = irq_en_q;
  assign o_irq    = irq_q;
`else
  assign irq_en_s = 1'b0;
  assign o_irq    = 1'b0;
`endif

  // Next-state logic for the sequencer FSM, counters and status flags.
  always_comb begin
    state_d       = state_q;
    steps_d       = steps_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    cyc_d         = cyc_q;
    shadow_d      = shadow_q;
    done_d        = done_q;
    aborted_d     = aborted_q;
    start_err_d   = start_err_q;

    if (steps_wr_s) begin
      steps_d = i_writedata[STEP_W-1:0];
    end else begin
      steps_d = steps_q;
    end

    // Reading CYC_LO latches the upper word, so a later CYC_HI read
    // pairs with this low word even if a carry occurs in between.
    if (i_read && (i_address == 3'd3)) begin
      shadow_d = cyc_q[CNT_W-1:32];
    end else begin
      shadow_d = shadow_q;
    end

    case ({stim_xfer_s, res_xfer_s})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // The counter saturates at all-ones. A CSR write overrides it.
    if (busy_s && (cyc_q != '1)) begin
      cyc_d = cyc_q + CNT_W'(1);
    end else begin
      cyc_d = cyc_q;
    end
    if (cyc_lo_wr_s) begin
      cyc_d[31:0] = i_writedata;
    end else begin
      cyc_d[31:0] = cyc_d[31:0];
    end
    if (cyc_hi_wr_s) begin
      cyc_d[CNT_W-1:32] = i_writedata[HI_W-1:0];
    end else begin
      cyc_d[CNT_W-1:32] = cyc_d[CNT_W-1:32];
    end

    // W1C happens first, so an event on the same edge still sets its flag.
    if (status_wr_s) begin
      done_d      = done_q      && !i_writedata[1];
      aborted_d   = aborted_q   && !i_writedata[2];
      start_err_d = start_err_q && !i_writedata[3];
    end else begin
      done_d      = done_q;
      aborted_d   = aborted_q;
      start_err_d = start_err_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // If start and abort arrive in the same write, abort wins. Abort
        // has no effect here, so such a write does nothing.
        if (start_req_s && !abort_req_s) begin
          remaining_d = steps_q;
          cyc_d       = '0;
          aborted_d   = 1'b0;
          if (steps_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            done_d  = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (stim_xfer_s) begin
          remaining_d = remaining_q - STEP_W'(1);
        end else begin
          remaining_d = remaining_q;
        end
        if (abort_req_s) begin
          state_d   = ST_DRAIN;
          aborted_d = 1'b1;
        end else if (stim_xfer_s && (remaining_q == STEP_W'(1))) begin
          state_d = ST_DRAIN;
          if (start_req_s) begin
            start_err_d = 1'b1;
          end else begin
            start_err_d = start_err_d;
          end
        end else begin
          state_d = ST_RUN;
          if (start_req_s) begin
            start_err_d = 1'b1;
          end else begin
            start_err_d = start_err_d;
          end
        end
      end
      ST_DRAIN: begin
        if (start_req_s && !abort_req_s) begin
          start_err_d = 1'b1;
        end else begin
          start_err_d = start_err_d;
        end
        if (outstanding_d == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, counters and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      steps_q       <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      cyc_q         <= '0;
      shadow_q      <= '0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      start_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      steps_q       <= steps_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      cyc_q         <= cyc_d;
      shadow_q      <= shadow_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      start_err_q   <= start_err_d;
    end
  end

  // Combinational CSR read mux. Unmapped addresses read as zero.
  always_comb begin
    logic [31:0] hi_ext;
    logic [31:0] steps_ext;
    logic [32:0] out_ext;
    hi_ext                 = '0;
    hi_ext[HI_W-1:0]       = shadow_q;
    steps_ext              = '0;
    steps_ext[STEP_W-1:0]  = steps_q;
    out_ext                = '0;
    out_ext[OUT_W-1:0]     = outstanding_q;
    case (i_address)
      3'd0:    o_readdata = {29'd0, irq_en_s, 2'd0};
      3'd1:    o_readdata = steps_ext;
      3'd2:    o_readdata = {28'd0, start_err_q, aborted_q, done_q, busy_s};
      3'd3:    o_readdata = cyc_q[31:0];
      3'd4:    o_readdata = hi_ext;
      3'd5:    o_readdata = out_ext[31:0];
      default: o_readdata = 32'd0;
    endcase
  end

endmodule
